// File: rtl/vec_lsu_pkg.sv
// Shared constants and FSM state type for the vector load/store sequencer.
package vlsu_pkg;
    localparam int DEF_VLMAX = 8;
    localparam int DEF_XLEN  = 32;
    localparam int IDX_W     = $clog2(DEF_VLMAX);
    localparam int CNT_W     = $clog2(DEF_VLMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/vec_lsu_if.sv
// Word-addressed data memory port. The sequencer is the master. Read data is
// registered by the memory and is valid one cycle after the address.
interface vec_lsu_if #(parameter int XLEN = vlsu_pkg::DEF_XLEN);
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_write_data;
    logic            mem_write_en;
    logic            stg_en;
    logic [XLEN-1:0] mem_data;

    modport master (output mem_addr, mem_write_data, mem_write_en, stg_en, input mem_data);
    modport slave  (input mem_addr, mem_write_data, mem_write_en, stg_en, output mem_data);
endinterface

// File: rtl/vec_lsu_addr_gen.sv
// Element counter and strided address accumulator; addr is the address of the
// element currently on the bus and holds its value once the count is exhausted.
module vlsu_addr_gen #(
    parameter int VLMAX = vlsu_pkg::DEF_VLMAX,
    parameter int XLEN  = vlsu_pkg::DEF_XLEN,
    parameter int IW    = vlsu_pkg::IDX_W,
    parameter int CW    = vlsu_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] stride,
    input  logic [CW-1:0]   count,
    output logic [XLEN-1:0] addr,
    output logic [IW-1:0]   idx,
    output logic            last
);
    logic [XLEN-1:0] stride_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            idx      <= '0;
            stride_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            addr     <= base;
            idx      <= '0;
            stride_q <= stride;
            count_q  <= count;
        end else if (advance) begin
            // Modular accumulation: wrap past 2^XLEN is intentional and silent.
            addr <= addr + stride_q;
            idx  <= idx + IW'(1);
        end
    end

    assign last = ((CW'(idx) + CW'(1)) == count_q);
endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer: one element per cycle on the data memory port.
// Optional per-element masking is enabled with the VLSU_MASK_EN macro.
module vec_lsu
    import vlsu_pkg::*;
#(
    parameter int VLMAX = DEF_VLMAX,
    parameter int XLEN  = DEF_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [XLEN-1:0]          base_addr,
    input  logic [XLEN-1:0]          stride,
    input  logic [$clog2(VLMAX+1)-1:0] vl,
    input  logic [VLMAX*XLEN-1:0]    vs_data,
`ifdef VLSU_MASK_EN
    input  logic [VLMAX-1:0]         vmask,
`endif
    output logic [VLMAX*XLEN-1:0]    vd_data,
    output logic                     busy,
    output logic                     done,
    output state_t                   state,
    vec_lsu_if.master                mem
);
    localparam int IW = (VLMAX > 1) ? $clog2(VLMAX) : 1;
    localparam int CW = $clog2(VLMAX + 1);

    state_t              state_nxt;
    logic                st_q;
    logic [VLMAX*XLEN-1:0] vs_q;
    logic [VLMAX-1:0]    mask_in;
    logic [VLMAX-1:0]    mask_q;
    logic [CW-1:0]       vl_clamp;
    logic                accept, launch, advance, last;
    logic [IW-1:0]       idx;
    logic [XLEN-1:0]     addr;
    logic                issue_next, nxt_store, nxt_act;
    logic [IW-1:0]       nxt_idx;
    logic [XLEN-1:0]     nxt_wdata;
    logic                stg_q, we_q;
    logic [XLEN-1:0]     wdata_q;
    logic                cap_valid;
    logic [IW-1:0]       cap_idx;

`ifdef VLSU_MASK_EN
    assign mask_in = vmask;
`else
    assign mask_in = '1;
`endif

    assign vl_clamp = (vl > CW'(VLMAX)) ? CW'(VLMAX) : vl;
    assign accept   = (state == IDLE) && start;
    assign launch   = accept && (vl_clamp != '0);
    assign advance  = (state == ISSUE) && !last;

    vlsu_addr_gen #(.VLMAX(VLMAX), .XLEN(XLEN), .IW(IW), .CW(CW)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (launch),
        .advance (advance),
        .base    (base_addr),
        .stride  (stride),
        .count   (vl_clamp),
        .addr    (addr),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (vl_clamp != '0) ? ISSUE : DONE;
            ISSUE: if (last)  state_nxt = st_q ? DONE : DRAIN;
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Describe the element that will be on the bus next cycle, so that every
    // mem_* output can be a plain register.
    always_comb begin
        issue_next = launch;
        nxt_idx    = '0;
        nxt_store  = is_store;
        nxt_act    = mask_in[0];
        nxt_wdata  = vs_data[XLEN-1:0];
        if (state == ISSUE) begin
            issue_next = !last;
            nxt_idx    = idx + IW'(1);
            nxt_store  = st_q;
            nxt_act    = mask_q[nxt_idx];
            nxt_wdata  = vs_q[nxt_idx*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= 1'b0;
            vs_q      <= '0;
            mask_q    <= '0;
            stg_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            vd_data   <= '0;
        end else begin
            if (accept) begin
                st_q   <= is_store;
                vs_q   <= vs_data;
                mask_q <= mask_in;
            end
            // Masked loads still occupy the stage; masked stores are fully idle.
            stg_q <= issue_next && (!nxt_store || nxt_act);
            we_q  <= issue_next && nxt_store && nxt_act;
            if (issue_next && nxt_store && nxt_act) wdata_q <= nxt_wdata;
            cap_valid <= (state == ISSUE) && !st_q && mask_q[idx];
            cap_idx   <= idx;
            if (cap_valid) vd_data[cap_idx*XLEN +: XLEN] <= mem.mem_data;
        end
    end

    assign mem.mem_addr       = addr;
    assign mem.mem_write_data = wdata_q;
    assign mem.mem_write_en   = we_q;
    assign mem.stg_en         = stg_q;
endmodule

// File: tb/tb_vec_lsu.sv
// Self-checking bench for vec_lsu: directed vector table, reset abort, and
// randomized instructions checked against a per-instruction reference model.
module tb_vec_lsu;
    import vlsu_pkg::*;

    localparam int VL = DEF_VLMAX;
    localparam int XL = DEF_XLEN;
    localparam int CW = $clog2(VL + 1);
    localparam int VW = VL * XL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          is_store = 1'b0;
    logic [XL-1:0] base_addr = '0;
    logic [XL-1:0] stride = '0;
    logic [CW-1:0] vl = '0;
    logic [VW-1:0] vs_data = '0;
    logic [VL-1:0] vmask = '1;
    logic [VW-1:0] vd_data;
    logic          busy, done;
    state_t        state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_lsu_if #(.XLEN(XL)) mem_bus();

    vec_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .stride    (stride),
        .vl        (vl),
        .vs_data   (vs_data),
`ifdef VLSU_MASK_EN
        .vmask     (vmask),
`endif
        .vd_data   (vd_data),
        .busy      (busy),
        .done      (done),
        .state     (state),
        .mem       (mem_bus)
    );

    // Memory responder: addresses below 100 preload to 10, the rest to 15.
    logic [XL-1:0] bus_mem [logic [XL-1:0]];
    logic [XL-1:0] ref_mem [logic [XL-1:0]];
    logic [XL-1:0] vd_model [VL];

    function automatic logic [XL-1:0] dflt(input logic [XL-1:0] a);
        return (a < 100) ? XL'(10) : XL'(15);
    endfunction

    function automatic logic [XL-1:0] bus_rd(input logic [XL-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    function automatic logic [XL-1:0] ref_rd(input logic [XL-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (mem_bus.mem_write_en) bus_mem[mem_bus.mem_addr] = mem_bus.mem_write_data;
        if (mem_bus.stg_en && !mem_bus.mem_write_en) mem_bus.mem_data <= bus_rd(mem_bus.mem_addr);
    end

    function automatic logic [VW-1:0] pk4(input logic [XL-1:0] a, b, c, d);
        logic [VW-1:0] r;
        r = '0;
        r[0*XL +: XL] = a;
        r[1*XL +: XL] = b;
        r[2*XL +: XL] = c;
        r[3*XL +: XL] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs one instruction starting from an idle negedge (cycle C0). The model
    // derives every expected bus cycle, memory effect and vd value directly
    // from the instruction's rules; exp_done < 0 skips the table checks.
    task automatic run_instr(input bit st, input logic [XL-1:0] b, input logic [XL-1:0] s,
                             input int vl_req, input logic [VL-1:0] m, input logic [VW-1:0] d,
                             input int exp_done, input int exp_elems, input bit chk_vd,
                             input logic [VW-1:0] ev);
        int vlc, md, obs_done, elems;
        logic [VL-1:0] mk;
        logic [XL-1:0] ea [VL];
        logic [VW-1:0] vd_exp;
        bit el, exp_stg, exp_we;
`ifdef VLSU_MASK_EN
        mk = m;
`else
        mk = '1;
`endif
        vlc = (vl_req > VL) ? VL : vl_req;
        for (int k = 0; k < VL; k++) ea[k] = b + XL'(k) * s;
        for (int k = 0; k < vlc; k++) begin
            if (mk[k]) begin
                if (st) ref_mem[ea[k]] = d[k*XL +: XL];
                else    vd_model[k] = ref_rd(ea[k]);
            end
        end
        md = (vlc == 0) ? 1 : (st ? vlc + 1 : vlc + 2);
        vd_exp = '0;
        for (int k = 0; k < VL; k++) vd_exp[k*XL +: XL] = vd_model[k];

        start = 1'b1; is_store = st; base_addr = b; stride = s;
        vl = CW'(vl_req); vs_data = d; vmask = m;
        obs_done = 0; elems = 0;
        for (int c = 1; c <= md; c++) begin
            @(negedge clk);
            el      = (c <= vlc);
            exp_stg = el && (!st || mk[(c-1) % VL]);
            exp_we  = el && st && mk[(c-1) % VL];
            chk($sformatf("busy@C%0d", c), VW'(busy), VW'(1'b1));
            chk($sformatf("done@C%0d", c), VW'(done), VW'(c == md));
            chk($sformatf("stg_en@C%0d", c), VW'(mem_bus.stg_en), VW'(exp_stg));
            chk($sformatf("mem_write_en@C%0d", c), VW'(mem_bus.mem_write_en), VW'(exp_we));
            if (exp_stg) chk($sformatf("mem_addr@C%0d", c), VW'(mem_bus.mem_addr), VW'(ea[c-1]));
            if (exp_we)  chk($sformatf("mem_write_data@C%0d", c), VW'(mem_bus.mem_write_data),
                             VW'(d[(c-1)*XL +: XL]));
            if (mem_bus.stg_en) elems++;
            if (done && obs_done == 0) obs_done = c;
            if (c == md) begin
                chk("vd_data", vd_data, vd_exp);
                start = 1'b0;
            end else begin
                // Noise on the request inputs while busy must be ignored.
                start = 1'($urandom_range(0, 1));
                is_store = 1'($urandom); base_addr = $urandom; stride = $urandom;
                vl = CW'($urandom); vmask = VL'($urandom);
                vs_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
        end
        if (exp_done >= 0) begin
            chk("done_cycle", VW'(obs_done), VW'(exp_done));
            chk("elem_count", VW'(elems), VW'(exp_elems));
        end
        if (chk_vd) chk("vd_table", VW'(vd_data[4*XL-1:0]), ev);
        @(negedge clk);
        chk("idle_busy", VW'(busy), VW'(1'b0));
        chk("idle_done", VW'(done), VW'(1'b0));
    endtask

    typedef struct {
        bit            st;
        logic [XL-1:0] base;
        logic [XL-1:0] strd;
        int            vlen;
        logic [VW-1:0] data;
        int            exp_done;
        int            exp_elems;
        bit            chk_vd;
        logic [VW-1:0] ev;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    task automatic reset_abort();
        logic [VW-1:0] d;
        d = pk4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        start = 1'b1; is_store = 1'b1; base_addr = 200; stride = 1; vl = CW'(4); vs_data = d; vmask = '1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mem_addr", VW'(mem_bus.mem_addr), '0);
        chk("rst_wdata", VW'(mem_bus.mem_write_data), '0);
        chk("rst_we", VW'(mem_bus.mem_write_en), '0);
        chk("rst_stg", VW'(mem_bus.stg_en), '0);
        chk("rst_busy", VW'(busy), '0);
        chk("rst_done", VW'(done), '0);
        chk("rst_vd", vd_data, '0);
        chk("rst_state", VW'(state), VW'(IDLE));
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("abort_mem200", VW'(bus_rd(200)), VW'(32'hA0));
        chk("abort_mem201", VW'(bus_rd(201)), VW'(32'hA1));
        chk("abort_mem202", VW'(bus_rd(202)), VW'(15));
        chk("abort_mem203", VW'(bus_rd(203)), VW'(15));
        ref_mem[200] = 32'hA0;
        ref_mem[201] = 32'hA1;
        for (int k = 0; k < VL; k++) vd_model[k] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [XL-1:0] rb, rs;
        for (int k = 0; k < VL; k++) vd_model[k] = '0;

        tbl[0] = '{1'b0, 98, 1, 4, '0, 6, 4, 1'b1, pk4(10, 10, 15, 15)};
        tbl[1] = '{1'b1, 5, 2, 3, pk4(1, 2, 3, 0), 4, 3, 1'b0, '0};
        tbl[2] = '{1'b0, 5, 2, 3, '0, 5, 3, 1'b1, pk4(1, 2, 3, 15)};
        tbl[3] = '{1'b0, 10, 32'hFFFF_FFFF, 3, '0, 5, 3, 1'b1, pk4(10, 3, 10, 15)};
        tbl[4] = '{1'b1, 40, 1, 0, pk4(99, 99, 99, 99), 1, 0, 1'b0, '0};
        tbl[5] = '{1'b0, 0, 1, 12, '0, 10, 8, 1'b1, pk4(10, 10, 10, 10)};
        tbl[6] = '{1'b0, 32'hFFFF_FFFE, 1, 4, '0, 6, 4, 1'b1, pk4(15, 15, 10, 10)};
        tbl[7] = '{1'b1, 60, 0, 2, pk4(7, 8, 0, 0), 3, 2, 1'b0, '0};
        tbl[8] = '{1'b0, 60, 1, 1, '0, 3, 1, 1'b1, pk4(8, 15, 10, 10)};

        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", VW'(busy), '0);
        chk("reset_done", VW'(done), '0);
        chk("reset_stg", VW'(mem_bus.stg_en), '0);
        chk("reset_we", VW'(mem_bus.mem_write_en), '0);
        chk("reset_addr", VW'(mem_bus.mem_addr), '0);
        chk("reset_vd", vd_data, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            run_instr(tbl[i].st, tbl[i].base, tbl[i].strd, tbl[i].vlen, '1, tbl[i].data,
                      tbl[i].exp_done, tbl[i].exp_elems, tbl[i].chk_vd, tbl[i].ev);

`ifdef VLSU_MASK_EN
        run_instr(1'b1, 300, 1, 4, VL'(4'b0101), pk4(32'hB0, 32'hB1, 32'hB2, 32'hB3), 5, 2, 1'b0, '0);
        run_instr(1'b0, 300, 1, 4, '1, '0, 6, 4, 1'b1, pk4(32'hB0, 15, 32'hB2, 15));
        run_instr(1'b0, 5, 2, 3, VL'(3'b010), '0, 5, 3, 1'b1, pk4(32'hB0, 2, 32'hB2, 15));
`endif

        reset_abort();

        for (int i = 0; i < 40; i++) begin
            rb = ($urandom_range(0, 1) == 0) ? XL'($urandom_range(0, 200)) : XL'($urandom);
            case ($urandom_range(0, 3))
                0:       rs = XL'($urandom_range(0, 3));
                1:       rs = 32'hFFFF_FFFF;
                2:       rs = XL'($urandom);
                default: rs = 1;
            endcase
            run_instr(1'($urandom), rb, rs, $urandom_range(0, 10), VL'($urandom),
                      {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      -1, 0, 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_lsu.md
# vec_lsu

Vector load/store sequencer for the RV32V datapath. Accepts one unit- or constant-stride vector memory instruction and drives the word-addressed data memory port: address, write data, write enable, stage enable. It issues one element per cycle and collects load data returned one cycle after each address. It sits between vector decode/register-file read and the data memory, as the initiator on the data memory port.

## Interface
- VLMAX, 8, maximum elements per instruction.
- XLEN, 32, element and address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- is_store  in  1  1 = store, 0 = load; latched at start.
- base_addr  in  XLEN  word index of element 0; latched at start.
- stride  in  XLEN  word stride, two's complement; latched at start.
- vl  in  $clog2(VLMAX+1)  active element count; latched at start.
- vs_data  in  VLMAX*XLEN  store data, element k at [k*XLEN +: XLEN]; snapshotted at start.
- vd_data  out  VLMAX*XLEN  load result register, same packing.
- busy  out  1  instruction in progress, including the done cycle.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  XLEN  word index to data memory.
- mem_write_data  out  XLEN  store data to data memory.
- mem_write_en  out  1  write strobe.
- stg_en  out  1  stage enable; high on every element cycle, load or store.
- mem_data  in  XLEN  registered memory read data; valid one cycle after mem_addr.

## Operation
- Reset: all outputs 0, vd_data 0, FSM to IDLE. Reset mid-instruction aborts immediately; no further writes are issued, and writes already committed stay.
- FSM states: IDLE -> ISSUE (vl>0) or DONE (vl=0); ISSUE -> DRAIN (load, after last element) or DONE (store, after last element); DRAIN -> DONE; DONE -> IDLE.
- vl > VLMAX is clamped to VLMAX at latch time.
- Element address: addr_k = base_addr + k*stride, computed by accumulation and taken mod 2^XLEN. Wrap-around is silent.
- Store element cycle: mem_addr=addr_k, mem_write_data=element k, mem_write_en=1, stg_en=1.
- Load element cycle: mem_addr=addr_k, mem_write_en=0, stg_en=1. mem_data is captured into vd_data element k on the following edge.
- Load elements k>=vl keep their prior vd_data value (tail-undisturbed).
- Outside element cycles: mem_write_en=0 and stg_en=0. mem_addr and mem_write_data hold their last value.
- start while busy=1 is ignored.

## Timing
- Cycle C0: start=1 sampled with busy=0. All mem_* outputs and busy are registered.
- busy=1 from C1 through the done cycle. A new start is accepted from the cycle after done.
- Element k is on the memory bus in cycle C(k+1), for k=0..vl-1. Accesses are back-to-back with no bubbles.
- Store: last write commits at the end of C(vl); done=1 in C(vl+1).
- Load: element k arrives on mem_data in C(k+2). vd_data is final and done=1 in C(vl+2).
- vl=0: no stg_en; done=1 in C1.

## Configuration
- VLSU_MASK_EN defined:
  - Adds input vmask [VLMAX-1:0], latched at start; element k is active when vmask[k]=1.
  - Masked-off store element: its cycle still elapses, but stg_en=0 and mem_write_en=0.
  - Masked-off load element: its cycle still elapses with stg_en=1, but vd_data element k is unchanged.
  - Latency is identical to the unmasked case.
- VLSU_MASK_EN undefined: no vmask port; all elements below vl are active.

## Structure
- Package vlsu_pkg holds:
  - VLMAX and XLEN defaults.
  - State enum: IDLE, ISSUE, DRAIN, DONE.
  - Element-index width constant.
- Sub-module vlsu_addr_gen holds the element counter and address accumulator. It has load/advance controls, outputs addr and last, and is reset by rst.

## Test plan
- Preload mem[0..99]=10 and mem[100..]=15. Load base=98, stride=1, vl=4 -> vd elements 0..3 = 10,10,15,15; done in C6; stg_en high C1..C4.
- Store base=5, stride=2, vl=3, data 1,2,3 -> writes at 5,7,9 in C1..C3, done in C4. A following load of the same addresses returns 1,2,3.
- Load base=10, stride=0xFFFFFFFF, vl=3 -> mem_addr sequence 10,9,8.
- vl=0 -> done in C1, stg_en and mem_write_en never asserted. vl=12 -> exactly 8 element cycles.
- Assert rst in C3 of a store with vl=4 -> only elements 0 and 1 are written; all outputs go to 0 asynchronously.
- With VLSU_MASK_EN defined: store vl=4, vmask=4'b0101 -> writes only elements 0 and 2; done still in C5.
